// File: rtl/jpeg_bit_feeder.sv
// jpeg_bit_feeder: serialises entropy-coded JPEG bytes MSB-first, removing 0xFF00 stuffing and fill bytes.
// Markers halt the bit stream until the parser acknowledges them.
module jpeg_bit_feeder #(
  parameter bit STUFF_EN  = 1'b1,
  parameter bit FILL_SKIP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_byte_in,
  input  logic       i_byte_valid,
  output logic       o_byte_ready,
  output logic       o_bit_out,
  output logic       o_bit_valid,
  input  logic       i_bit_ready,
  input  logic       i_flush,
  output logic       o_marker_valid,
  output logic [7:0] o_marker_code,
  output logic       o_marker_is_rst,
  input  logic       i_marker_ack,
  output logic [3:0] o_bits_left
);
  typedef enum logic [1:0] {LOAD, SHIFT, FF_WAIT, MARKER} state_t;
  state_t     r_state, w_state_n;
  logic [7:0] r_shreg, w_shreg_n, r_marker_code, w_marker_code_n;
  logic [3:0] r_bits_left, w_bits_left_n;
  logic       r_marker_is_rst, w_marker_is_rst_n;
  logic       w_shift, w_last, w_accept, w_is_ff;
  assign o_bit_valid     = r_state == SHIFT;
  assign o_marker_valid  = r_state == MARKER;
  assign o_bit_out       = r_shreg[7];
  assign o_bits_left     = r_bits_left;
  assign o_marker_code   = r_marker_code;
  assign o_marker_is_rst = r_marker_is_rst;
  assign w_shift         = o_bit_valid && i_bit_ready;
  // last bit leaving this cycle: a new byte may load on the same edge
  assign w_last          = w_shift && r_bits_left == 4'd1;
  assign o_byte_ready    = !i_flush && (r_state == LOAD || r_state == FF_WAIT || w_last);
  assign w_accept        = i_byte_valid && o_byte_ready;
  assign w_is_ff         = STUFF_EN && i_byte_in == 8'hFF;
  always_comb begin
    w_state_n         = r_state;
    w_shreg_n         = r_shreg;
    w_bits_left_n     = r_bits_left;
    w_marker_code_n   = r_marker_code;
    w_marker_is_rst_n = r_marker_is_rst;
    if (i_flush) begin
      w_state_n     = LOAD;
      w_bits_left_n = 4'd0;
    end else begin
      case (r_state)
        LOAD, SHIFT: begin
          if (w_shift) begin
            w_shreg_n     = {r_shreg[6:0], 1'b0};
            w_bits_left_n = r_bits_left - 4'd1;
            w_state_n     = w_last ? LOAD : SHIFT;
          end
          if (w_accept && w_is_ff) w_state_n = FF_WAIT;
          else if (w_accept) begin
            w_shreg_n     = i_byte_in;
            w_bits_left_n = 4'd8;
            w_state_n     = SHIFT;
          end
        end
        FF_WAIT: begin
          if (w_accept && i_byte_in == 8'h00) begin
            w_shreg_n     = 8'hFF;
            w_bits_left_n = 4'd8;
            w_state_n     = SHIFT;
          end else if (w_accept && !(FILL_SKIP && i_byte_in == 8'hFF)) begin
            w_marker_code_n   = i_byte_in;
            w_marker_is_rst_n = i_byte_in[7:3] == 5'b11010;
            w_state_n         = MARKER;
          end
        end
        MARKER: w_state_n = i_marker_ack ? LOAD : MARKER;
        default: w_state_n = LOAD;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= LOAD;
      r_shreg         <= 8'h00;
      r_bits_left     <= 4'd0;
      r_marker_code   <= 8'h00;
      r_marker_is_rst <= 1'b0;
    end else begin
      r_state         <= w_state_n;
      r_shreg         <= w_shreg_n;
      r_bits_left     <= w_bits_left_n;
      r_marker_code   <= w_marker_code_n;
      r_marker_is_rst <= w_marker_is_rst_n;
    end
  end
endmodule
